// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the Kyber NTT address sequencer.
//   mode_t  : operation select (NTT, inverse NTT, pointwise basemul, reserved)
//   state_t : sequencer FSM states
//   LOG_N_DEF / LAT_DEF : default coefficient-count log2 and butterfly latency
package ntt_pkg;

    localparam int LOG_N_DEF = 8;
    localparam int LAT_DEF   = 6;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'd0,
        MODE_INTT = 2'd1,
        MODE_PWM  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/ntt_wb_delay.sv
// ntt_wb_delay: LAT-deep shift register carrying {valid, payload} from read
// issue to write-back. Shifts every cycle, so stall bubbles travel through.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_data   : entry entering the line this cycle
//   out_valid, out_data : entry leaving the line (LAT cycles later)
//   pending             : a valid entry sits in any slot but the output one,
//                         i.e. at least one more write-back is still to come
module ntt_wb_delay #(
    parameter int unsigned LAT = 6,
    parameter int unsigned W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         pending
);

    localparam logic [LAT-1:0] NOT_LAST = {LAT{1'b1}} >> 1;

    logic [LAT-1:0] vld;
    logic [W-1:0]   dat [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < LAT; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int unsigned i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_data  = dat[LAT-1];
    assign pending   = |(vld & NOT_LAST);

endmodule

// File: rtl/ntt_addr_sequencer.sv
// ntt_addr_sequencer: self-sequencing address / twiddle generator for the
// Kyber polynomial arithmetic unit.
//   clk, rst              : clock, asynchronous active-high reset
//   start, mode, en       : start request, operation (latched at accept), issue enable
//   busy, done, stage     : handshake status and current stage index
//   rd_valid, rd_addr_a/b : operand read pair issued this cycle
//   zeta_idx, zeta_neg    : twiddle ROM index, negate flag (basemul only)
//   wr_valid, wr_addr_a/b : read pair delayed by LAT for write-back
module ntt_addr_sequencer
    import ntt_pkg::*;
#(
    parameter int unsigned LOG_N = LOG_N_DEF,
    parameter int unsigned LAT   = LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             en,
    output logic             busy,
    output logic             done,
    output logic [2:0]       stage,
    output logic             rd_valid,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-2:0] zeta_idx,
    output logic             zeta_neg,
    output logic             wr_valid,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
);

    localparam int unsigned    NST       = LOG_N - 1;
    localparam int unsigned    BW        = LOG_N - 1;
    localparam logic [LOG_N-1:0] ONE     = LOG_N'(1);
    localparam logic [BW-1:0]  Z1        = BW'(1);
    localparam logic [2:0]     LAST_FULL = 3'(NST - 1);

    state_t           state;
    mode_t            mode_q;
    logic [2:0]       stage_q;
    logic [BW-1:0]    bf;

    logic [LOG_N-1:0] a_c, b_c, a_h, b_h;
    logic [BW-1:0]    z_c, z_h;
    logic             neg_c, neg_h;
    logic             issue, pending, last_stage;
    int unsigned      shamt;
    logic [BW-1:0]    grp, ofs;
    logic [2*LOG_N-1:0] wb_data;

    // Butterfly index -> operand pair and twiddle. shamt is log2 of the pair
    // distance; grp/ofs split bf into butterfly group and offset inside it.
    // Shifting Z1 by BW wraps to zero, which yields the all-ones mask and the
    // modular 2^BW term in the INTT twiddle without extra width.
    always_comb begin
        a_c   = '0;
        b_c   = '0;
        z_c   = '0;
        neg_c = 1'b0;
        shamt = 0;
        grp   = '0;
        ofs   = '0;
        if (mode_q == MODE_PWM) begin
            a_c   = {bf, 1'b0};
            b_c   = {bf, 1'b1};
            z_c   = (Z1 << (LOG_N - 2)) + (bf >> 1);
            neg_c = bf[0];
        end else begin
            shamt = (mode_q == MODE_INTT) ? 32'(stage_q) : NST - 32'(stage_q);
            grp   = bf >> shamt;
            ofs   = bf & ((Z1 << shamt) - Z1);
            a_c   = ({1'b0, grp} << (shamt + 1)) | {1'b0, ofs};
            b_c   = a_c + (ONE << shamt);
            z_c   = (mode_q == MODE_INTT) ? (Z1 << (NST - 32'(stage_q))) - Z1 - grp
                                          : (Z1 << stage_q) + grp;
        end
    end

    assign issue      = (state == S_RUN) && en;
    assign last_stage = (mode_q == MODE_PWM) ? (stage_q == 3'd0) : (stage_q == LAST_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            mode_q  <= MODE_NTT;
            stage_q <= '0;
            bf      <= '0;
            a_h     <= '0;
            b_h     <= '0;
            z_h     <= '0;
            neg_h   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && mode_t'(mode) != MODE_RSVD) begin
                        mode_q  <= mode_t'(mode);
                        stage_q <= '0;
                        bf      <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        a_h   <= a_c;
                        b_h   <= b_c;
                        z_h   <= z_c;
                        neg_h <= neg_c;
                        bf    <= bf + Z1;
                        if (bf == '1) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave once only the output slot may still hold a write,
                    // so the next read lands the cycle after the last write-back.
                    if (!pending) begin
                        if (last_stage) begin
                            state <= S_DONE;
                        end else begin
                            stage_q <= stage_q + 3'd1;
                            bf      <= '0;
                            state   <= S_RUN;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign stage     = stage_q;
    assign rd_valid  = issue;
    assign rd_addr_a = issue ? a_c   : a_h;
    assign rd_addr_b = issue ? b_c   : b_h;
    assign zeta_idx  = issue ? z_c   : z_h;
    assign zeta_neg  = issue ? neg_c : neg_h;

    ntt_wb_delay #(
        .LAT (LAT),
        .W   (2 * LOG_N)
    ) u_wb_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_data   ({rd_addr_a, rd_addr_b}),
        .out_valid (wr_valid),
        .out_data  (wb_data),
        .pending   (pending)
    );

    assign wr_addr_a = wb_data[2*LOG_N-1:LOG_N];
    assign wr_addr_b = wb_data[LOG_N-1:0];

endmodule
